// File: rtl/branch_predictor_pkg.sv
// Shared types for the gshare direction predictor.
package branch_predictor_pkg;

  // 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    STK = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_INIT = WNT;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next state of one 2-bit saturating direction counter.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t cur,
  input  logic    taken,
  output bp_ctr_t next
);

  // Step toward the resolved direction, holding at either end.
  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != STK) next = bp_ctr_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) next = bp_ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: 1-cycle lookup, training on resolved branches,
// non-speculative global history and saturating statistics counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [31:0]         req_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_pred_taken,
  output logic                mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  bp_ctr_t             table_q [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic [GHR_BITS-1:0] pred_ghr_q, pred_ghr_d;
  logic                mispredict_q, mispredict_d;
  logic [31:0]         branch_count_q, branch_count_d;
  logic [31:0]         mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  bp_ctr_t             upd_cur, upd_next;
  logic                is_mis;

  // Only the word-index bits of the PCs take part in hashing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[31:IDX_BITS+2], req_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  assign lk_idx  = req_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign upd_idx = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);
  assign upd_cur = table_q[upd_idx];
  assign is_mis  = upd_taken != upd_pred_taken;

  sat_ctr2 u_sat_ctr2 (
    .cur   (upd_cur),
    .taken (upd_taken),
    .next  (upd_next)
  );

  // Next-state for lookup pipe, history, mispredict pulse and statistics.
  always_comb begin
    pred_valid_d       = req_valid;
    pred_taken_d       = pred_taken_q;
    pred_ghr_d         = pred_ghr_q;
    ghr_d              = ghr_q;
    mispredict_d       = 1'b0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (req_valid) begin
      pred_taken_d = table_q[lk_idx][1];
      pred_ghr_d   = ghr_q;
    end
    if (upd_valid) begin
      ghr_d        = GHR_BITS'({ghr_q, upd_taken});
      mispredict_d = is_mis;
      if (branch_count_q != '1) branch_count_d = branch_count_q + 32'd1;
      if (is_mis && (mispredict_count_q != '1))
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  // State registers; the table is read above before this edge writes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= BP_CTR_INIT;
      ghr_q              <= '0;
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      pred_ghr_q         <= '0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (upd_valid) table_q[upd_idx] <= upd_next;
      ghr_q              <= ghr_d;
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      pred_ghr_q         <= pred_ghr_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_ghr         = pred_ghr_q;
  assign mispredict       = mispredict_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for the gshare predictor with a per-cycle scoreboard.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst, req_valid, upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] req_pc, upd_pc;
  logic [5:0]  upd_ghr;
  logic        pred_valid, pred_taken, mispredict;
  logic [5:0]  pred_ghr;
  logic [31:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .GHR_BITS(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_pc           (req_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_ghr         (pred_ghr),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_ghr          (upd_ghr),
    .upd_taken        (upd_taken),
    .upd_pred_taken   (upd_pred_taken),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic        pv;
    logic        pt;
    logic [5:0]  pg;
    logic        mis;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  // Reference model state
  logic [1:0]  m_tbl [64];
  logic [5:0]  m_ghr;
  logic        m_pv, m_pt, m_mis;
  logic [5:0]  m_pg;
  logic [31:0] m_bc, m_mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] idx);
    return {24'b0, idx ^ m_ghr, 2'b00};
  endfunction

  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic [5:0] ug,
                     input logic ut, input logic upt);
    exp_t e;
    logic [5:0] li, ui;
    rst = r; req_valid = rv; req_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut; upd_pred_taken = upt;
    if (r) begin
      for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
      m_ghr = '0; m_pv = 0; m_pt = 0; m_pg = '0; m_mis = 0; m_bc = '0; m_mc = '0;
    end else begin
      li = rpc[7:2] ^ m_ghr;
      ui = upc[7:2] ^ ug;
      m_pv = rv;
      if (rv) begin m_pt = m_tbl[li][1]; m_pg = m_ghr; end
      m_mis = uv && (ut != upt);
      if (uv) begin
        if (ut && m_tbl[ui] != 2'b11) m_tbl[ui] = m_tbl[ui] + 2'd1;
        else if (!ut && m_tbl[ui] != 2'b00) m_tbl[ui] = m_tbl[ui] - 2'd1;
        m_ghr = {m_ghr[4:0], ut};
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        if (m_mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      end
    end
    e.pv = m_pv; e.pt = m_pt; e.pg = m_pg; e.mis = m_mis; e.bc = m_bc; e.mc = m_mc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pred_valid", 32'(pred_valid), 32'(e.pv));
    chk("pred_taken", 32'(pred_taken), 32'(e.pt));
    chk("pred_ghr", 32'(pred_ghr), 32'(e.pg));
    chk("mispredict", 32'(mispredict), 32'(e.mis));
    chk("branch_count", branch_count, e.bc);
    chk("mispredict_count", mispredict_count, e.mc);
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 0, 32'h0, 6'h0, 0, 0);
  endtask

  logic        snap_t;
  logic [5:0]  snap_g;
  int unsigned late_mis;
  int unsigned bad_entries;
  logic [1:0]  walk [3];

  initial begin
    rst = 1; req_valid = 0; req_pc = '0; upd_valid = 0; upd_pc = '0;
    upd_ghr = '0; upd_taken = 0; upd_pred_taken = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // 1: first lookup after reset
    cyc(0, 1, 32'h40, 0, 0, 0, 0, 0);
    chk("t1_valid", 32'(pred_valid), 1);
    chk("t1_taken", 32'(pred_taken), 0);
    chk("t1_ghr", 32'(pred_ghr), 0);
    chk("t1_bcount", branch_count, 0);

    // 2: mispredicted taken update on entry 16
    cyc(0, 0, 0, 1, 32'h40, 6'h0, 1, 0);
    chk("t2_mis", 32'(mispredict), 1);
    chk("t2_mcount", mispredict_count, 1);
    chk("t2_entry16", 32'(dut.table_q[16]), 32'h2);
    idle();
    chk("t2_mis_pulse_end", 32'(mispredict), 0);
    cyc(0, 1, 32'h40, 0, 0, 0, 0, 0);
    chk("t2_lookup17", 32'(pred_taken), 0);
    chk("t2_ghr", 32'(pred_ghr), 32'h01);

    // 3: saturate index 32 upward, then walk it down with lookups in between
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 32'h80, 6'h0, 1, m_tbl[32][1]);
    chk("t3_sat_hi", 32'(dut.table_q[32]), 32'h3);
    cyc(0, 1, pc_for(6'd32), 0, 0, 0, 0, 0);
    chk("t3_pred_sat", 32'(pred_taken), 1);
    walk[0] = 2'b10; walk[1] = 2'b01; walk[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 32'h80, 6'h0, 0, m_tbl[32][1]);
      chk("t3_walk", 32'(dut.table_q[32]), 32'(walk[i]));
      cyc(0, 1, pc_for(6'd32), 0, 0, 0, 0, 0);
      chk("t3_walk_pred", 32'(pred_taken), 32'(walk[i][1]));
    end

    // 4: same-cycle lookup and update on index 40 (starts at 01)
    cyc(0, 1, pc_for(6'd40), 1, 32'hA0, 6'h0, 1, 0);
    chk("t4_same_cycle", 32'(pred_taken), 0);
    cyc(0, 1, pc_for(6'd40), 0, 0, 0, 0, 0);
    chk("t4_next_cycle", 32'(pred_taken), 1);

    // 5: alternating pattern on pc 0x100
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    late_mis = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(0, 1, 32'h100, 0, 0, 0, 0, 0);
      snap_t = pred_taken; snap_g = pred_ghr;
      cyc(0, 0, 0, 1, 32'h100, snap_g, (i % 2) == 0, snap_t);
      if (i >= 32 && mispredict) late_mis++;
    end
    chk("t5_late_mis", late_mis, 0);
    chk("t5_bcount", branch_count, 64);

    // 6: reset mid-stream, then saturation of branch_count
    for (int i = 0; i < 10; i++)
      cyc(0, 1, $urandom, 1, $urandom, 6'($urandom), 1'($urandom), 1'($urandom));
    cyc(1, 1, 32'h40, 1, 32'h40, 6'h0, 1, 0);
    chk("t6_valid", 32'(pred_valid), 0);
    chk("t6_bcount", branch_count, 0);
    chk("t6_mcount", mispredict_count, 0);
    chk("t6_ghr", 32'(dut.ghr_q), 0);
    bad_entries = 0;
    for (int i = 0; i < 64; i++) if (dut.table_q[i] !== 2'b01) bad_entries++;
    chk("t6_entries", bad_entries, 0);
    force dut.branch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    m_bc = 32'hFFFF_FFFF;
    cyc(0, 0, 0, 1, 32'h40, 6'h0, 1, 1);
    chk("t6_bcount_sat", branch_count, 32'hFFFF_FFFF);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
